rename_regfile: RTL and testbench
=================================

RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, giving the number of architectural registers (power of two, 4..64).
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the register data width.
REQ-003 The block SHALL have parameter TAG_W, default 6, giving the reservation-station tag width; tag 0 means "not redirected".
REQ-004 The block SHALL have parameter ZERO_REG, default 0; when 1, register 0 always reads 0 and is never redirected or written.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port issue, input, 1 bit: an instruction issues this cycle.
REQ-008 The block SHALL have ports A_address, B_address and dest, each input, log2(NUM_REGS) bits: the source operand and destination register indices.
REQ-009 The block SHALL have port RS_calculating_value, input, TAG_W bits: the tag of the station that will produce dest.
REQ-010 The block SHALL have port write, input, 1 bit: common-data-bus broadcast valid.
REQ-011 The block SHALL have ports In_data (input, DATA_W bits) and In_source (input, TAG_W bits): the broadcast value and its producing tag.
REQ-012 The block SHALL have port flush, input, 1 bit: clears all redirections (misprediction recovery).
REQ-013 The block SHALL have ports A_out and B_out, each output, DATA_W bits: operand value, or zero-extended tag when the matching invalid flag is 1.
REQ-014 The block SHALL have ports A_invalid and B_invalid, each output, 1 bit: 1 means the corresponding *_out carries a tag, not data.
REQ-015 The block SHALL have port out_valid, output, 1 bit: the operand outputs were updated by the previous edge's issue.
REQ-016 The block SHALL have port busy_count, output, log2(NUM_REGS)+1 bits: the number of registers currently redirected.

Function
REQ-017 On a rising edge with issue=1 and flush=0, the block SHALL register each source operand as follows: if its tag is 0, the output is reg_file data and invalid=0; otherwise the output is the tag and invalid=1; out_valid SHALL be 1 for that one cycle.
REQ-018 Same-cycle bypass: if a source tag is nonzero, write=1 and In_source equals that tag, the block SHALL output In_data with invalid=0.
REQ-019 Sources SHALL be looked up against the pre-edge mapping, so an instruction whose dest equals a source sees the old mapping.
REQ-020 Issue SHALL set the tag of dest to RS_calculating_value; issue with RS_calculating_value=0 SHALL leave the dest mapping unchanged.
REQ-021 On a rising edge with write=1 and a nonzero In_source, every register whose tag equals In_source SHALL load In_data and clear its tag to 0.
REQ-022 Issue and write to the same dest in the same cycle: reg_file SHALL take In_data and the tag SHALL take the new issue tag, so issue wins.
REQ-023 Write with In_source=0 SHALL have no effect.
REQ-024 flush=1 SHALL clear all tags to 0 at the edge, SHALL suppress issue (out_valid=0, no tag set), and SHALL still let a concurrent write update data.
REQ-025 When ZERO_REG=1, reads of register 0 SHALL return 0 with invalid=0, and issue or write SHALL never alter it.
REQ-026 busy_count SHALL be registered, SHALL equal the number of nonzero tags after each edge, and SHALL never exceed NUM_REGS.
REQ-027 Operand outputs SHALL hold their values while issue=0; only out_valid drops to 0.

Reset
REQ-028 While reset_n=0, the block SHALL asynchronously set reg_file[i]=i (truncated to DATA_W), all tags to 0, A_out, B_out, A_invalid, B_invalid and out_valid to 0, and busy_count to 0.
REQ-029 Reset asserted mid-operation SHALL discard all pending redirections; after deassertion, the first rising edge behaves per REQ-017 through REQ-027.

Verification
REQ-030 The bench SHALL cover: after reset, issue A=3, B=5, dest=7, tag=9 -> next cycle A_out=3, B_out=5, invalids 0, out_valid=1, busy_count=1.
REQ-031 The bench SHALL cover: then issue A=7 -> A_out=9 with A_invalid=1; then write In_source=9, In_data=0xDEAD -> reg 7 reads 0xDEAD and busy_count=0.
REQ-032 The bench SHALL cover: tag 12 pending on reg 4, then issue A=4 with write In_source=12, In_data=0x55 in the same cycle -> A_out=0x55, A_invalid=0.
REQ-033 The bench SHALL cover: issue dest=2, tag=8 with write In_source=4 in the same cycle while reg 2 holds tag 4 -> reg 2 data updated and tag=8, busy_count unchanged.
REQ-034 The bench SHALL cover: with five registers redirected, flush with a concurrent issue -> busy_count=0, out_valid=0, and a later read of those registers returns their data.
REQ-035 The bench SHALL cover: ZERO_REG=1, issue dest=0, tag=3 followed by read A=0 -> A_out=0, A_invalid=0; and reset_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/rename_regfile.sv
// rename_regfile
//   Register file with Tomasulo-style renaming. Each architectural register
//   holds a data word and a reservation-station tag. A nonzero tag means the
//   register is waiting on that station. The common data bus clears the
//   waiting tags and loads the data.
//
// Parameters
//   NUM_REGS  number of architectural registers (power of two, 4..64)
//   DATA_W    register data width
//   TAG_W     reservation-station tag width; tag 0 = not redirected
//   ZERO_REG  1: register 0 is hard-wired to zero and never renamed
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   issue                 instruction issues this cycle
//   A_address, B_address  source operand register indices
//   dest                  destination register index
//   RS_calculating_value  tag of the station that will produce dest
//   write, In_data,       common-data-bus broadcast: valid, value and
//   In_source             producing tag
//   flush                 drop every redirection (misprediction recovery)
//   A_out, B_out          operand data, or the zero-extended tag if invalid
//   A_invalid, B_invalid  1 = matching *_out carries a tag
//   out_valid             operands were updated by the previous edge's issue
//   busy_count            number of registers currently redirected
module rename_regfile #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned TAG_W    = 6,
   parameter bit          ZERO_REG = 1'b0
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         issue,
   input  logic [$clog2(NUM_REGS)-1:0]  A_address,
   input  logic [$clog2(NUM_REGS)-1:0]  B_address,
   input  logic [$clog2(NUM_REGS)-1:0]  dest,
   input  logic [TAG_W-1:0]             RS_calculating_value,
   input  logic                         write,
   input  logic [DATA_W-1:0]            In_data,
   input  logic [TAG_W-1:0]             In_source,
   input  logic                         flush,
   output logic [DATA_W-1:0]            A_out,
   output logic [DATA_W-1:0]            B_out,
   output logic                         A_invalid,
   output logic                         B_invalid,
   output logic                         out_valid,
   output logic [$clog2(NUM_REGS):0]    busy_count
);

   localparam int unsigned AW = $clog2(NUM_REGS);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] reg_file      [NUM_REGS];
   logic [TAG_W-1:0]  tag           [NUM_REGS];
   logic [DATA_W-1:0] reg_file_next [NUM_REGS];
   logic [TAG_W-1:0]  tag_next      [NUM_REGS];
   logic [CW-1:0]     busy_next;
   logic [DATA_W:0]   a_look;
   logic [DATA_W:0]   b_look;
   logic              do_issue;
   logic              do_write;

   assign do_issue = issue & ~flush;
   assign do_write = write & (In_source != '0);

   // Operand lookup against the pre-edge mapping. The result is {invalid, value}.
   // A broadcast of the awaited tag in the same cycle bypasses straight to data.
   function automatic logic [DATA_W:0] lookup(input logic [AW-1:0] idx);
      logic [TAG_W-1:0] t;
      t = tag[idx];
      if (ZERO_REG && idx == '0)
         return '0;
      else if (t == '0)
         return {1'b0, reg_file[idx]};
      else if (write && In_source == t)
         return {1'b0, In_data};
      else
         return {1'b1, DATA_W'(t)};
   endfunction

   always_comb begin
      a_look = lookup(A_address);
      b_look = lookup(B_address);
   end

   // Priority per register: the broadcast clears the tag and loads data, then
   // a new issue overrides the tag, then flush clears every tag. Data still
   // follows the broadcast.
   always_comb begin
      busy_next = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         reg_file_next[i] = reg_file[i];
         tag_next[i]      = tag[i];
         if (do_write && tag[i] == In_source) begin
            reg_file_next[i] = In_data;
            tag_next[i]      = '0;
         end
         if (do_issue && RS_calculating_value != '0 && dest == AW'(i))
            tag_next[i] = RS_calculating_value;
         if (flush)
            tag_next[i] = '0;
         if (ZERO_REG && i == 0) begin
            reg_file_next[i] = reg_file[i];
            tag_next[i]      = '0;
         end
         if (tag_next[i] != '0)
            busy_next = busy_next + CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_file[i] <= DATA_W'(i);
            tag[i]      <= '0;
         end
         A_out      <= '0;
         B_out      <= '0;
         A_invalid  <= 1'b0;
         B_invalid  <= 1'b0;
         out_valid  <= 1'b0;
         busy_count <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_file[i] <= reg_file_next[i];
            tag[i]      <= tag_next[i];
         end
         busy_count <= busy_next;
         out_valid  <= do_issue;
         if (do_issue) begin
            A_out     <= a_look[DATA_W-1:0];
            A_invalid <= a_look[DATA_W];
            B_out     <= b_look[DATA_W-1:0];
            B_invalid <= b_look[DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_rename_regfile.sv
module tb_rename_regfile;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        issue = 1'b0;
   logic [4:0]  A_address = '0;
   logic [4:0]  B_address = '0;
   logic [4:0]  dest = '0;
   logic [5:0]  RS_calculating_value = '0;
   logic        write = 1'b0;
   logic [31:0] In_data = '0;
   logic [5:0]  In_source = '0;
   logic        flush = 1'b0;

   logic [31:0] a_out0, b_out0, a_out1, b_out1;
   logic        a_inv0, b_inv0, ov0, a_inv1, b_inv1, ov1;
   logic [5:0]  busy0, busy1;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   rename_regfile #(.NUM_REGS(32), .DATA_W(32), .TAG_W(6), .ZERO_REG(1'b0)) u_dut (
      .clock(clock), .reset_n(reset_n), .issue(issue),
      .A_address(A_address), .B_address(B_address), .dest(dest),
      .RS_calculating_value(RS_calculating_value), .write(write),
      .In_data(In_data), .In_source(In_source), .flush(flush),
      .A_out(a_out0), .B_out(b_out0), .A_invalid(a_inv0), .B_invalid(b_inv0),
      .out_valid(ov0), .busy_count(busy0));

   rename_regfile #(.NUM_REGS(32), .DATA_W(32), .TAG_W(6), .ZERO_REG(1'b1)) u_dutz (
      .clock(clock), .reset_n(reset_n), .issue(issue),
      .A_address(A_address), .B_address(B_address), .dest(dest),
      .RS_calculating_value(RS_calculating_value), .write(write),
      .In_data(In_data), .In_source(In_source), .flush(flush),
      .A_out(a_out1), .B_out(b_out1), .A_invalid(a_inv1), .B_invalid(b_inv1),
      .out_valid(ov1), .busy_count(busy1));

   typedef struct {
      logic        iss;
      logic [4:0]  a, b, d;
      logic [5:0]  rs;
      logic        wr;
      logic [31:0] din;
      logic [5:0]  src;
      logic        fl;
      logic [31:0] ea;
      logic        eai;
      logic [31:0] eb;
      logic        ebi;
      logic        eov;
      logic [5:0]  ebusy;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iss, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [5:0] rs, input logic wr,
                        input logic [31:0] din, input logic [5:0] src, input logic fl);
      issue = iss; A_address = a; B_address = b; dest = d;
      RS_calculating_value = rs; write = wr; In_data = din; In_source = src; flush = fl;
   endtask

   task automatic step;
      @(posedge clock);
      #1;
      drive(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic add(input logic iss, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [5:0] rs, input logic wr,
                      input logic [31:0] din, input logic [5:0] src, input logic fl,
                      input logic [31:0] ea, input logic eai, input logic [31:0] eb,
                      input logic ebi, input logic eov, input logic [5:0] ebusy);
      vec_t v;
      v.iss = iss; v.a = a; v.b = b; v.d = d; v.rs = rs; v.wr = wr; v.din = din;
      v.src = src; v.fl = fl; v.ea = ea; v.eai = eai; v.eb = eb; v.ebi = ebi;
      v.eov = eov; v.ebusy = ebusy;
      vq.push_back(v);
   endtask

   initial begin
      //   iss a   b   d   rs  wr din          src fl | A_out        Ai B_out   Bi ov busy
      // basic issue, then read the renamed register, then broadcast it back
      add(1, 3,  5,  7,  9,  0, 32'h0,       0,  0,   32'd3,       0, 32'd5,  0, 1, 1);
      add(1, 7,  1,  10, 0,  0, 32'h0,       0,  0,   32'd9,       1, 32'd1,  0, 1, 1);
      add(0, 0,  0,  0,  0,  1, 32'hDEAD,    9,  0,   32'd9,       1, 32'd1,  0, 0, 0);
      add(1, 7,  7,  10, 0,  0, 32'h0,       0,  0,   32'hDEAD,    0, 32'hDEAD,0,1, 0);
      // same-cycle bypass of a pending tag
      add(1, 1,  2,  4,  12, 0, 32'h0,       0,  0,   32'd1,       0, 32'd2,  0, 1, 1);
      add(1, 4,  4,  11, 0,  1, 32'h55,      12, 0,   32'h55,      0, 32'h55, 0, 1, 0);
      // issue and write to the same dest: data from bus, tag from issue
      add(1, 3,  6,  2,  4,  0, 32'h0,       0,  0,   32'd3,       0, 32'd6,  0, 1, 1);
      add(1, 2,  2,  2,  8,  1, 32'h1234,    4,  0,   32'h1234,    0, 32'h1234,0,1, 1);
      add(1, 2,  5,  12, 0,  0, 32'h0,       0,  0,   32'd8,       1, 32'd5,  0, 1, 1);
      add(0, 0,  0,  0,  0,  0, 32'h0,       0,  1,   32'd8,       1, 32'd5,  0, 0, 0);
      add(1, 2,  4,  12, 0,  0, 32'h0,       0,  0,   32'h1234,    0, 32'h55, 0, 1, 0);
      // five redirections, then flush with concurrent issue and write
      add(1, 13, 14, 13, 20, 0, 32'h0,       0,  0,   32'd13,      0, 32'd14, 0, 1, 1);
      add(1, 13, 14, 14, 21, 0, 32'h0,       0,  0,   32'd20,      1, 32'd14, 0, 1, 2);
      add(1, 15, 16, 15, 22, 0, 32'h0,       0,  0,   32'd15,      0, 32'd16, 0, 1, 3);
      add(1, 16, 15, 16, 23, 0, 32'h0,       0,  0,   32'd16,      0, 32'd22, 1, 1, 4);
      add(1, 17, 16, 17, 24, 0, 32'h0,       0,  0,   32'd17,      0, 32'd23, 1, 1, 5);
      add(1, 13, 14, 18, 25, 1, 32'hABC,     22, 1,   32'd17,      0, 32'd23, 1, 0, 0);
      add(1, 13, 15, 10, 0,  0, 32'h0,       0,  0,   32'd13,      0, 32'hABC,0, 1, 0);
      add(1, 18, 17, 10, 0,  0, 32'h0,       0,  0,   32'd18,      0, 32'd17, 0, 1, 0);
      // broadcast with tag 0 touches nothing
      add(1, 18, 19, 10, 0,  1, 32'hFFFF,    0,  0,   32'd18,      0, 32'd19, 0, 1, 0);

      #2;
      chk("reset A_out", a_out0, 32'h0);
      chk("reset A_invalid", {31'b0, a_inv0}, 32'h0);
      chk("reset out_valid", {31'b0, ov0}, 32'h0);
      chk("reset busy", {26'b0, busy0}, 32'h0);
      #10;
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      foreach (vq[k]) begin
         drive(vq[k].iss, vq[k].a, vq[k].b, vq[k].d, vq[k].rs, vq[k].wr,
               vq[k].din, vq[k].src, vq[k].fl);
         step();
         for (int u = 0; u < 2; u++) begin
            string p;
            p = $sformatf("v%0d.u%0d ", k, u);
            chk({p, "A_out"},     u == 0 ? a_out0 : a_out1, vq[k].ea);
            chk({p, "A_invalid"}, {31'b0, u == 0 ? a_inv0 : a_inv1}, {31'b0, vq[k].eai});
            chk({p, "B_out"},     u == 0 ? b_out0 : b_out1, vq[k].eb);
            chk({p, "B_invalid"}, {31'b0, u == 0 ? b_inv0 : b_inv1}, {31'b0, vq[k].ebi});
            chk({p, "out_valid"}, {31'b0, u == 0 ? ov0 : ov1}, {31'b0, vq[k].eov});
            chk({p, "busy"},      {26'b0, u == 0 ? busy0 : busy1}, {26'b0, vq[k].ebusy});
         end
      end

      // Register 0: renamed in the plain instance, hard-wired in ZERO_REG one
      drive(1, 1, 1, 0, 3, 0, 32'h0, 0, 0);
      step();
      chk("zr busy plain", {26'b0, busy0}, 32'd1);
      chk("zr busy zero",  {26'b0, busy1}, 32'd0);
      drive(1, 0, 0, 10, 0, 0, 32'h0, 0, 0);
      step();
      chk("zr A plain", a_out0, 32'd3);
      chk("zr Ainv plain", {31'b0, a_inv0}, 32'd1);
      chk("zr A zero", a_out1, 32'd0);
      chk("zr Ainv zero", {31'b0, a_inv1}, 32'd0);
      drive(0, 0, 0, 0, 0, 1, 32'h99, 3, 0);
      step();
      drive(1, 0, 0, 10, 0, 0, 32'h0, 0, 0);
      step();
      chk("zr wr A plain", a_out0, 32'h99);
      chk("zr wr A zero", a_out1, 32'd0);
      chk("zr wr busy plain", {26'b0, busy0}, 32'd0);

      // Reset mid-run: outputs clear immediately, mapping and data return to reset
      drive(1, 6, 8, 5, 7, 0, 32'h0, 0, 0);
      step();
      chk("pre-rst busy", {26'b0, busy0}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst A_out", a_out0, 32'h0);
      chk("rst B_out", b_out0, 32'h0);
      chk("rst out_valid", {31'b0, ov0}, 32'h0);
      chk("rst busy", {26'b0, busy0}, 32'h0);
      chk("rst zero A_out", a_out1, 32'h0);
      #10;
      reset_n = 1'b1;
      drive(1, 5, 7, 10, 0, 0, 32'h0, 0, 0);
      step();
      chk("post-rst A_out", a_out0, 32'd5);
      chk("post-rst A_invalid", {31'b0, a_inv0}, 32'd0);
      chk("post-rst B_out", b_out0, 32'd7);
      chk("post-rst out_valid", {31'b0, ov0}, 32'd1);
      chk("post-rst busy", {26'b0, busy0}, 32'd0);
      step();
      chk("hold A_out", a_out0, 32'd5);
      chk("hold out_valid", {31'b0, ov0}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
